// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 Set-2 scancode decoder:
//   - parser state encoding
//   - prefix and controller byte values
//   - modifier key codes and bit positions inside the mods vector
//   - is_ctrl_byte(): identifies keyboard controller/status bytes
// ----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } ps2_state_t;

  // Prefix bytes
  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;

  // Controller / status bytes
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_EE = 8'hEE;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  // Modifier key codes (ctrl/alt right-hand variants are E0-prefixed)
  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_ALT    = 8'h11;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  // Extended keys with an ASCII meaning
  localparam logic [7:0] KEY_KP_SLASH = 8'h4A;
  localparam logic [7:0] KEY_KP_ENTER = 8'h5A;

  // Bit positions in mods_o
  localparam int MODS_W     = 7;
  localparam int MOD_LSHIFT = 0;
  localparam int MOD_RSHIFT = 1;
  localparam int MOD_LCTRL  = 2;
  localparam int MOD_RCTRL  = 3;
  localparam int MOD_LALT   = 4;
  localparam int MOD_RALT   = 5;
  localparam int MOD_CAPS   = 6;

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_FE) ||
           (b == BYTE_EE) || (b == BYTE_00) || (b == BYTE_FF);
  endfunction

endpackage

// File: rtl/ps2_set2_ascii.sv
// ----------------------------------------------------------------------------
// ps2_set2_ascii
// Pure combinational Set-2 -> US ASCII lookup.
// Ports:
//   i_code  [7:0] base scancode, prefixes stripped
//   i_ext         code was E0-prefixed
//   i_shift       either shift key held
//   i_caps        caps lock active (affects letters only)
//   o_ascii [7:0] ASCII character, 8'h00 when unmapped
// ----------------------------------------------------------------------------
module ps2_set2_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_ext,
  input  logic       i_shift,
  input  logic       i_caps,
  output logic [7:0] o_ascii
);

  logic       w_letter;
  logic [7:0] w_lo;
  logic [7:0] w_hi;

  always_comb begin
    w_letter = 1'b0;
    w_lo     = 8'h00;
    w_hi     = 8'h00;
    case (i_code)
      8'h1C: {w_letter, w_lo, w_hi} = {1'b1, "a", "A"};
      8'h32: {w_letter, w_lo, w_hi} = {1'b1, "b", "B"};
      8'h21: {w_letter, w_lo, w_hi} = {1'b1, "c", "C"};
      8'h23: {w_letter, w_lo, w_hi} = {1'b1, "d", "D"};
      8'h24: {w_letter, w_lo, w_hi} = {1'b1, "e", "E"};
      8'h2B: {w_letter, w_lo, w_hi} = {1'b1, "f", "F"};
      8'h34: {w_letter, w_lo, w_hi} = {1'b1, "g", "G"};
      8'h33: {w_letter, w_lo, w_hi} = {1'b1, "h", "H"};
      8'h43: {w_letter, w_lo, w_hi} = {1'b1, "i", "I"};
      8'h3B: {w_letter, w_lo, w_hi} = {1'b1, "j", "J"};
      8'h42: {w_letter, w_lo, w_hi} = {1'b1, "k", "K"};
      8'h4B: {w_letter, w_lo, w_hi} = {1'b1, "l", "L"};
      8'h3A: {w_letter, w_lo, w_hi} = {1'b1, "m", "M"};
      8'h31: {w_letter, w_lo, w_hi} = {1'b1, "n", "N"};
      8'h44: {w_letter, w_lo, w_hi} = {1'b1, "o", "O"};
      8'h4D: {w_letter, w_lo, w_hi} = {1'b1, "p", "P"};
      8'h15: {w_letter, w_lo, w_hi} = {1'b1, "q", "Q"};
      8'h2D: {w_letter, w_lo, w_hi} = {1'b1, "r", "R"};
      8'h1B: {w_letter, w_lo, w_hi} = {1'b1, "s", "S"};
      8'h2C: {w_letter, w_lo, w_hi} = {1'b1, "t", "T"};
      8'h3C: {w_letter, w_lo, w_hi} = {1'b1, "u", "U"};
      8'h2A: {w_letter, w_lo, w_hi} = {1'b1, "v", "V"};
      8'h1D: {w_letter, w_lo, w_hi} = {1'b1, "w", "W"};
      8'h22: {w_letter, w_lo, w_hi} = {1'b1, "x", "X"};
      8'h35: {w_letter, w_lo, w_hi} = {1'b1, "y", "Y"};
      8'h1A: {w_letter, w_lo, w_hi} = {1'b1, "z", "Z"};
      8'h16: {w_lo, w_hi} = {"1", "!"};
      8'h1E: {w_lo, w_hi} = {"2", "@"};
      8'h26: {w_lo, w_hi} = {"3", "#"};
      8'h25: {w_lo, w_hi} = {"4", "$"};
      8'h2E: {w_lo, w_hi} = {"5", "%"};
      8'h36: {w_lo, w_hi} = {"6", "^"};
      8'h3D: {w_lo, w_hi} = {"7", "&"};
      8'h3E: {w_lo, w_hi} = {"8", "*"};
      8'h46: {w_lo, w_hi} = {"9", "("};
      8'h45: {w_lo, w_hi} = {"0", ")"};
      8'h4E: {w_lo, w_hi} = {"-", "_"};
      8'h55: {w_lo, w_hi} = {"=", "+"};
      8'h54: {w_lo, w_hi} = {"[", "{"};
      8'h5B: {w_lo, w_hi} = {"]", "}"};
      8'h5D: {w_lo, w_hi} = {8'h5C, 8'h7C};
      8'h4C: {w_lo, w_hi} = {";", ":"};
      8'h52: {w_lo, w_hi} = {8'h27, 8'h22};
      8'h0E: {w_lo, w_hi} = {8'h60, 8'h7E};
      8'h41: {w_lo, w_hi} = {",", "<"};
      8'h49: {w_lo, w_hi} = {".", ">"};
      8'h4A: {w_lo, w_hi} = {"/", "?"};
      8'h29: {w_lo, w_hi} = {" ", " "};
      8'h5A: {w_lo, w_hi} = {8'h0D, 8'h0D};
      8'h66: {w_lo, w_hi} = {8'h08, 8'h08};
      8'h0D: {w_lo, w_hi} = {8'h09, 8'h09};
      8'h76: {w_lo, w_hi} = {8'h1B, 8'h1B};
      default: ;
    endcase
  end

  always_comb begin
    o_ascii = 8'h00;
    if (i_ext) begin
      if (i_code == KEY_KP_SLASH)      o_ascii = 8'h2F;
      else if (i_code == KEY_KP_ENTER) o_ascii = 8'h0D;
    end else if (w_letter) begin
      // Caps lock only inverts the shift sense for letters
      o_ascii = (i_shift ^ i_caps) ? w_hi : w_lo;
    end else begin
      o_ascii = i_shift ? w_hi : w_lo;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ----------------------------------------------------------------------------
// ps2_scancode_decoder
// Turns raw PS/2 Set-2 bytes into key events: strips E0/F0/E1 prefixes,
// filters controller bytes, tracks modifiers/caps lock and translates to ASCII.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   byte_valid_i/byte_i     raw byte stream in; byte_ready_o accepts
//   evt_valid_o/evt_ready_i event output handshake
//   evt_code_o              base code (00 for PAUSE)
//   evt_ext_o/evt_brk_o     E0-prefixed / release flags
//   evt_ctl_o               controller byte passed through (FILTER_CTRL=0)
//   evt_pause_o             PAUSE key event
//   evt_ascii_o             ASCII for printable make events
//   mods_o                  {caps,ralt,lalt,rctrl,lctrl,rshift,lshift}
//   ctl_seen_o              pulse when a controller byte is dropped
// ----------------------------------------------------------------------------
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int PAUSE_SKIP  = 7,
  parameter bit FILTER_CTRL = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [7:0]        evt_code_o,
  output logic              evt_ext_o,
  output logic              evt_brk_o,
  output logic              evt_ctl_o,
  output logic              evt_pause_o,
  output logic [7:0]        evt_ascii_o,
  output logic [MODS_W-1:0] mods_o,
  output logic              ctl_seen_o
);

  ps2_state_t        r_state;
  ps2_state_t        w_state_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;

  logic              r_evt_valid;
  logic [7:0]        r_evt_code;
  logic              r_evt_ext;
  logic              r_evt_brk;
  logic              r_evt_ctl;
  logic              r_evt_pause;
  logic [7:0]        r_evt_ascii;
  logic [MODS_W-1:0] r_mods;
  logic              r_caps_held;
  logic              r_ctl_seen;

  logic              w_accept;
  logic              w_is_ctrl;
  logic              w_is_prefix;
  logic              w_key_ext;
  logic              w_key_brk;
  logic              w_emit_key;
  logic              w_emit_ctl;
  logic              w_emit_pause;
  logic              w_drop_ctl;
  logic              w_load;
  logic [MODS_W-1:0] w_mods_nxt;
  logic              w_caps_held_nxt;
  logic [7:0]        w_ascii;
  logic [7:0]        w_evt_code_nxt;
  logic [7:0]        w_evt_ascii_nxt;

  assign byte_ready_o = ~r_evt_valid | evt_ready_i;
  assign w_accept     = byte_valid_i & byte_ready_o;
  assign w_is_ctrl    = is_ctrl_byte(byte_i);
  assign w_key_ext    = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign w_key_brk    = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);

  // E0 only acts as a prefix before any F0; after F0 it is taken as a code
  assign w_is_prefix  = (byte_i == BYTE_E1) || (byte_i == BYTE_F0) ||
                        ((byte_i == BYTE_E0) &&
                         ((r_state == ST_IDLE) || (r_state == ST_EXT)));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      if (r_state == ST_PAUSE) begin
        if (r_cnt <= 8'd1) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end else if (w_is_ctrl) begin
        w_state_nxt = ST_IDLE;
      end else if (byte_i == BYTE_E1) begin
        w_state_nxt = ST_PAUSE;
        w_cnt_nxt   = 8'(PAUSE_SKIP);
      end else if (byte_i == BYTE_F0) begin
        w_state_nxt = (r_state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
      end else if (w_is_prefix) begin
        w_state_nxt = ST_EXT;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // Output decisions and modifier update
  always_comb begin
    w_emit_key      = 1'b0;
    w_emit_ctl      = 1'b0;
    w_emit_pause    = 1'b0;
    w_drop_ctl      = 1'b0;
    w_mods_nxt      = r_mods;
    w_caps_held_nxt = r_caps_held;
    if (w_accept) begin
      if (r_state == ST_PAUSE) begin
        w_emit_pause = (r_cnt <= 8'd1);
      end else if (w_is_ctrl) begin
        w_drop_ctl = FILTER_CTRL;
        w_emit_ctl = ~FILTER_CTRL;
      end else if (!w_is_prefix) begin
        w_emit_key = 1'b1;
      end
    end
    if (w_emit_key) begin
      if (!w_key_ext) begin
        if (byte_i == KEY_LSHIFT) w_mods_nxt[MOD_LSHIFT] = ~w_key_brk;
        if (byte_i == KEY_RSHIFT) w_mods_nxt[MOD_RSHIFT] = ~w_key_brk;
        if (byte_i == KEY_CTRL)   w_mods_nxt[MOD_LCTRL]  = ~w_key_brk;
        if (byte_i == KEY_ALT)    w_mods_nxt[MOD_LALT]   = ~w_key_brk;
        if (byte_i == KEY_CAPS) begin
          // Typematic repeats keep caps_held set, so only the first make toggles
          if (!w_key_brk && !r_caps_held)
            w_mods_nxt[MOD_CAPS] = ~r_mods[MOD_CAPS];
          w_caps_held_nxt = ~w_key_brk;
        end
      end else begin
        if (byte_i == KEY_CTRL) w_mods_nxt[MOD_RCTRL] = ~w_key_brk;
        if (byte_i == KEY_ALT)  w_mods_nxt[MOD_RALT]  = ~w_key_brk;
      end
    end
  end

  assign w_load = w_emit_key | w_emit_ctl | w_emit_pause;

  ps2_set2_ascii u_ascii (
    .i_code  (byte_i),
    .i_ext   (w_key_ext),
    .i_shift (r_mods[MOD_LSHIFT] | r_mods[MOD_RSHIFT]),
    .i_caps  (r_mods[MOD_CAPS]),
    .o_ascii (w_ascii)
  );

  assign w_evt_code_nxt  = w_emit_pause ? 8'h00 : byte_i;
  assign w_evt_ascii_nxt = (w_emit_key && !w_key_brk) ? w_ascii : 8'h00;

  // ---- Output register stage ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_evt_valid <= 1'b0;
      r_evt_code  <= 8'h00;
      r_evt_ext   <= 1'b0;
      r_evt_brk   <= 1'b0;
      r_evt_ctl   <= 1'b0;
      r_evt_pause <= 1'b0;
      r_evt_ascii <= 8'h00;
      r_mods      <= '0;
      r_caps_held <= 1'b0;
      r_ctl_seen  <= 1'b0;
    end else begin
      r_ctl_seen <= w_drop_ctl;
      if (w_load) begin
        r_evt_valid <= 1'b1;
        r_evt_code  <= w_evt_code_nxt;
        r_evt_ext   <= w_emit_key & w_key_ext;
        r_evt_brk   <= w_emit_key & w_key_brk;
        r_evt_ctl   <= w_emit_ctl;
        r_evt_pause <= w_emit_pause;
        r_evt_ascii <= w_evt_ascii_nxt;
        r_mods      <= w_mods_nxt;
        r_caps_held <= w_caps_held_nxt;
      end else if (evt_ready_i) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign evt_valid_o = r_evt_valid;
  assign evt_code_o  = r_evt_code;
  assign evt_ext_o   = r_evt_ext;
  assign evt_brk_o   = r_evt_brk;
  assign evt_ctl_o   = r_evt_ctl;
  assign evt_pause_o = r_evt_pause;
  assign evt_ascii_o = r_evt_ascii;
  assign mods_o      = r_mods;
  assign ctl_seen_o  = r_ctl_seen;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_valid;
  logic [7:0] byte_d;
  logic       byte_ready;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       evt_ctl;
  logic       evt_pause;
  logic [7:0] evt_ascii;
  logic [6:0] mods;
  logic       ctl_seen;

  int n_chk = 0;
  int n_err = 0;
  int n_evt;

  always #5 clk = ~clk;

  ps2_scancode_decoder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_valid_i (byte_valid),
    .byte_i       (byte_d),
    .byte_ready_o (byte_ready),
    .evt_valid_o  (evt_valid),
    .evt_ready_i  (evt_ready),
    .evt_code_o   (evt_code),
    .evt_ext_o    (evt_ext),
    .evt_brk_o    (evt_brk),
    .evt_ctl_o    (evt_ctl),
    .evt_pause_o  (evt_pause),
    .evt_ascii_o  (evt_ascii),
    .mods_o       (mods),
    .ctl_seen_o   (ctl_seen)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte, wait (bounded) until accepted; returns #1 after the accept edge
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    byte_d     = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) chk("send_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_d     = 8'h00;
    evt_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_valid", evt_valid, 0);
    chk("rst_mods", mods, 0);
    chk("rst_ctl_seen", ctl_seen, 0);
    chk("rst_code", evt_code, 0);
    chk("rst_ready", byte_ready, 1);

    // Plain make
    send(8'h1C);
    chk("a_valid", evt_valid, 1);
    chk("a_code", evt_code, 8'h1C);
    chk("a_extbrk", {evt_ext, evt_brk}, 0);
    chk("a_ascii", evt_ascii, 8'h61);

    // Shift
    send(8'h12);
    chk("lshift_mods", mods, 7'h01);
    chk("lshift_ascii", evt_ascii, 0);
    send(8'h1C);
    chk("A_ascii", evt_ascii, 8'h41);
    send(8'hF0);
    chk("f0_no_evt", evt_valid, 0);
    send(8'h1C);
    chk("a_brk", evt_brk, 1);
    chk("a_brk_ascii", evt_ascii, 0);
    send(8'hF0);
    send(8'h12);
    chk("lshift_brk_code", evt_code, 8'h12);
    chk("lshift_clr_mods", mods, 7'h00);

    // Right ctrl
    send(8'hE0);
    send(8'h14);
    chk("rctrl_ext", {evt_ext, evt_brk}, 2'b10);
    chk("rctrl_mods", mods, 7'h08);
    send(8'hE0);
    send(8'hF0);
    send(8'h14);
    chk("rctrl_brk_flags", {evt_ext, evt_brk}, 2'b11);
    chk("rctrl_clr_mods", mods, 7'h00);

    // Caps lock with typematic repeat
    send(8'h58);
    chk("caps1", mods, 7'h40);
    send(8'h1C);
    chk("caps_A", evt_ascii, 8'h41);
    send(8'h58);
    chk("caps2", mods, 7'h40);
    send(8'hF0);
    send(8'h58);
    chk("caps3", mods, 7'h40);
    send(8'h58);
    chk("caps4", mods, 7'h00);
    send(8'h1C);
    chk("caps_off_a", evt_ascii, 8'h61);

    // Pause sequence: exactly one event
    n_evt = 0;
    send(8'hE1); if (evt_valid) n_evt++;
    send(8'h14); if (evt_valid) n_evt++;
    send(8'h77); if (evt_valid) n_evt++;
    send(8'hE1); if (evt_valid) n_evt++;
    send(8'hF0); if (evt_valid) n_evt++;
    send(8'h14); if (evt_valid) n_evt++;
    send(8'hF0); if (evt_valid) n_evt++;
    send(8'h77); if (evt_valid) n_evt++;
    chk("pause_count", n_evt, 1);
    chk("pause_last_valid", evt_valid, 1);
    chk("pause_flag", evt_pause, 1);
    chk("pause_code", evt_code, 0);
    chk("pause_ascii", evt_ascii, 0);
    chk("pause_mods", mods, 0);

    // Backpressure
    send(8'h1C);
    evt_ready = 1'b0;
    #1;
    chk("bp_ready_low", byte_ready, 0);
    byte_d     = 8'h32;
    byte_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold_valid", evt_valid, 1);
    chk("bp_hold_code", evt_code, 8'h1C);
    evt_ready = 1'b1;
    #1;
    chk("bp_release_code", evt_code, 8'h1C);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk("bp_next_valid", evt_valid, 1);
    chk("bp_next_code", evt_code, 8'h32);

    // Controller byte filtering
    send(8'hAA);
    chk("aa_pulse", ctl_seen, 1);
    chk("aa_no_evt", evt_valid, 0);
    @(posedge clk);
    #1;
    chk("aa_pulse_end", ctl_seen, 0);
    send(8'hE0);
    send(8'hAA);
    send(8'h1C);
    chk("e0aa_code", evt_code, 8'h1C);
    chk("e0aa_ext", evt_ext, 0);

    // Reset in the middle of a prefix
    send(8'hE0);
    send(8'hF0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", evt_valid, 0);
    send(8'h1C);
    chk("midrst_code", evt_code, 8'h1C);
    chk("midrst_flags", {evt_ext, evt_brk}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
